// File: rtl/enc8b10b_pkg.sv
// Shared 8b/10b constants: RD encodings, RD- sub-block tables, K28/A7/P7 codes and the legal K list.
// Used by enc8b10b_classify and enc8b10b_disparity_encoder.
package enc8b10b_pkg;

    localparam logic RD_NEG = 1'b0;
    localparam logic RD_POS = 1'b1;

    localparam logic [5:0] K28_6B_NEG = 6'b001111;
    localparam logic [3:0] P7_NEG     = 4'b1110;
    localparam logic [3:0] A7_NEG     = 4'b0111;
    localparam logic [7:0] K28_5_BYTE = 8'hBC;

    // abcdei for EDCBA = 0..31, RD- column
    localparam logic [5:0] TBL6_NEG [32] = '{
        6'b100111, 6'b011101, 6'b101101, 6'b110001, 6'b110101, 6'b101001, 6'b011001, 6'b111000,
        6'b111001, 6'b100101, 6'b010101, 6'b110100, 6'b001101, 6'b101100, 6'b011100, 6'b010111,
        6'b011011, 6'b100011, 6'b010011, 6'b110010, 6'b001011, 6'b101010, 6'b011010, 6'b111010,
        6'b110011, 6'b100110, 6'b010110, 6'b110110, 6'b001110, 6'b101110, 6'b011110, 6'b101011
    };

    // fghj for HGF = 0..7, RD- column (x.7 holds the primary P7 form)
    localparam logic [3:0] TBL4_NEG [8] = '{
        4'b1011, 4'b1001, 4'b0101, 4'b1100, 4'b1101, 4'b1010, 4'b0110, P7_NEG
    };

    localparam logic [7:0] K7_LEGAL [4] = '{8'hF7, 8'hFB, 8'hFD, 8'hFE};

    typedef struct packed {
        logic [5:0] c6;
        logic [3:0] c4;
        logic       u6;
        logic       u4;
        logic       d7;
        logic       x3;
        logic       y7;
        logic       alt_neg;
        logic       alt_pos;
        logic       k28;
        logic       kerr;
    } enc_class_t;

    function automatic logic is_legal_k(input logic [7:0] b);
        logic ok;
        ok = (b[4:0] == 5'd28);
        for (int unsigned i = 0; i < 4; i++) begin
            if (b == K7_LEGAL[i]) ok = 1'b1;
        end
        return ok;
    endfunction

endpackage

// File: rtl/enc8b10b_classify.sv
// Combinational 5b/6b + 3b/4b classification of one byte; forms the S1 next-state.
// ENC8B10B_KERR_EN: illegal K bytes are flagged and substituted with K28.5.
module enc8b10b_classify
    import enc8b10b_pkg::*;
(
    input  logic [7:0] i_data,
    input  logic       i_k,
    output enc_class_t o_class
);

    logic [7:0] w_byte;
    logic       w_kerr;
    logic [4:0] w_x;
    logic [2:0] w_y;
    logic       w_k28;
    logic       w_y7;
    logic [5:0] w_c6;
    logic [3:0] w_c4;

`ifdef ENC8B10B_KERR_EN
    assign w_kerr = i_k & ~is_legal_k(i_data);
    assign w_byte = w_kerr ? K28_5_BYTE : i_data;
`else
    assign w_kerr = 1'b0;
    assign w_byte = i_data;
`endif

    assign w_x   = w_byte[4:0];
    assign w_y   = w_byte[7:5];
    assign w_k28 = i_k & (w_x == 5'd28);
    assign w_y7  = (w_y == 3'd7);
    assign w_c6  = w_k28 ? K28_6B_NEG : TBL6_NEG[w_x];
    assign w_c4  = TBL4_NEG[w_y];

    // Any K.y.7 takes A7; data bytes only for the e=i run-length cases
    always_comb begin
        o_class         = '0;
        o_class.c6      = w_c6;
        o_class.c4      = w_c4;
        o_class.u6      = ($countones(w_c6) != 3);
        o_class.u4      = ($countones(w_c4) != 2);
        o_class.d7      = (w_c6 == 6'b111000);
        o_class.x3      = (w_y == 3'd3);
        o_class.y7      = w_y7;
        o_class.alt_neg = w_y7 & (i_k | (w_x == 5'd17) | (w_x == 5'd18) | (w_x == 5'd20));
        o_class.alt_pos = w_y7 & (i_k | (w_x == 5'd11) | (w_x == 5'd13) | (w_x == 5'd14));
        o_class.k28     = w_k28;
        o_class.kerr    = w_kerr;
    end

endmodule

// File: rtl/enc8b10b_disparity_encoder.sv
// Two-stage registered 8b/10b encoder: S1 holds the classified byte, S2 applies running disparity.
// Optional illegal-K detection via ENC8B10B_KERR_EN (see enc8b10b_classify).
module enc8b10b_disparity_encoder
    import enc8b10b_pkg::*;
#(
    parameter logic RD_INIT = 1'b0
)
(
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] data_in,
    input  logic       k_in,
    input  logic       valid_in,
    output logic       ready_out,
    output logic [9:0] code_out,
    output logic       valid_out,
    input  logic       ready_in,
    output logic       rd_out,
    output logic       kerr_out
);

    enc_class_t w_s1_next;
    enc_class_t r_s1;
    logic       r_s1_valid;
    logic       r_valid_out;
    logic [9:0] r_code;
    logic       r_rd;
    logic       r_kerr;

    logic       w_s2_ready;
    logic       w_s1_ready;
    logic       w_rd_eff;
    logic       w_rd_mid;
    logic       w_alt;
    logic [5:0] w_c6;
    logic [3:0] w_c4b;
    logic [3:0] w_c4;
    logic [9:0] w_code;
    logic       w_rd_next;

    enc8b10b_classify u_classify (
        .i_data  (data_in),
        .i_k     (k_in),
        .o_class (w_s1_next)
    );

    assign w_s2_ready = ~r_valid_out | ready_in;
    assign w_s1_ready = ~r_s1_valid | w_s2_ready;

    // K28 is built in its RD- form and fully inverted for RD+, which keeps the comma polarity
    always_comb begin
        w_rd_eff  = r_s1.k28 ? RD_NEG : r_rd;
        w_c6      = ((r_s1.u6 | r_s1.d7) & w_rd_eff) ? ~r_s1.c6 : r_s1.c6;
        w_rd_mid  = w_rd_eff ^ r_s1.u6;
        w_alt     = r_s1.y7 & (w_rd_mid ? r_s1.alt_pos : r_s1.alt_neg);
        w_c4b     = w_alt ? A7_NEG : r_s1.c4;
        w_c4      = ((r_s1.u4 | r_s1.x3) & w_rd_mid) ? ~w_c4b : w_c4b;
        w_code    = {w_c6, w_c4};
        w_rd_next = w_rd_mid ^ r_s1.u4;
        if (r_s1.k28 && (r_rd == RD_POS)) begin
            w_code    = ~w_code;
            w_rd_next = ~w_rd_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s1       <= '0;
        end else if (w_s1_ready) begin
            r_s1_valid <= valid_in;
            if (valid_in) r_s1 <= w_s1_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid_out <= 1'b0;
            r_code      <= '0;
            r_rd        <= RD_INIT;
            r_kerr      <= 1'b0;
        end else if (w_s2_ready) begin
            r_valid_out <= r_s1_valid;
            r_kerr      <= r_s1_valid & r_s1.kerr;
            if (r_s1_valid) begin
                r_code <= w_code;
                r_rd   <= w_rd_next;
            end
        end
    end

    assign ready_out = w_s1_ready;
    assign code_out  = r_code;
    assign valid_out = r_valid_out;
    assign rd_out    = r_rd;
    assign kerr_out  = r_kerr;

endmodule

// File: tb/tb_enc8b10b_disparity_encoder.sv
// Directed self-checking bench for enc8b10b_disparity_encoder; K-error expectations follow ENC8B10B_KERR_EN.
module tb_enc8b10b_disparity_encoder;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] data_in = '0;
    logic       k_in = 1'b0;
    logic       valid_in = 1'b0;
    logic       ready_in = 1'b1;
    logic       ready_out;
    logic [9:0] code_out;
    logic       valid_out;
    logic       rd_out;
    logic       kerr_out;

    int n_checks = 0;
    int n_fail   = 0;

    logic [8:0]  in_q  [$];
    logic [11:0] exp_q [$];

    always #5 clk = ~clk;

    enc8b10b_disparity_encoder #(.RD_INIT(1'b0)) dut (
        .clk       (clk),
        .rst       (rst),
        .data_in   (data_in),
        .k_in      (k_in),
        .valid_in  (valid_in),
        .ready_out (ready_out),
        .code_out  (code_out),
        .valid_out (valid_out),
        .ready_in  (ready_in),
        .rd_out    (rd_out),
        .kerr_out  (kerr_out)
    );

    task automatic chk(input string tag, input logic [9:0] obs, input logic [9:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic add(input logic k, input logic [7:0] d, input logic [9:0] code,
                       input logic rd, input logic kerr);
        in_q.push_back({k, d});
        exp_q.push_back({kerr, rd, code});
    endtask

    // Streams in_q back to back; ready_in is low for the first stall_len cycles.
    task automatic run_stream(input string tag, input int stall_len);
        int         n;
        int         sent;
        int         got;
        int         first_pop;
        int         last_pop;
        int         stall_acc;
        logic       acc;
        logic       pop;
        logic       ro_low;
        logic       held_valid;
        logic [9:0] held_code;
        logic       held_rd;
        logic [11:0] e;
        n = in_q.size();
        sent = 0; got = 0; first_pop = -1; last_pop = -1; stall_acc = 0;
        ro_low = 1'b0; held_valid = 1'b0; held_code = '0; held_rd = 1'b0;
        for (int cyc = 0; cyc < 60 && got < n; cyc++) begin
            ready_in = (cyc >= stall_len);
            valid_in = (sent < n);
            {k_in, data_in} = (sent < n) ? in_q[sent] : 9'h000;
            #1;
            if (held_valid) begin
                chk($sformatf("%s frozen_code c%0d", tag, cyc), code_out, held_code);
                chk($sformatf("%s frozen_rd c%0d", tag, cyc), {9'b0, rd_out}, {9'b0, held_rd});
            end
            acc = valid_in & ready_out;
            pop = valid_out & ready_in;
            held_valid = valid_out & ~ready_in;
            held_code  = code_out;
            held_rd    = rd_out;
            if (cyc < stall_len && acc) stall_acc++;
            if (cyc == stall_len - 1) ro_low = ~ready_out;
            if (pop) begin
                e = exp_q[got];
                chk($sformatf("%s code[%0d]", tag, got), code_out, e[9:0]);
                chk($sformatf("%s rd[%0d]", tag, got), {9'b0, rd_out}, {9'b0, e[10]});
                chk($sformatf("%s kerr[%0d]", tag, got), {9'b0, kerr_out}, {9'b0, e[11]});
                if (first_pop < 0) first_pop = cyc;
                last_pop = cyc;
                got++;
            end
            if (acc) sent++;
            @(posedge clk); #1;
        end
        valid_in = 1'b0;
        ready_in = 1'b1;
        chk($sformatf("%s all_out", tag), 10'(got), 10'(n));
        if (stall_len == 0) begin
            chk($sformatf("%s latency", tag), 10'(first_pop), 10'd2);
            chk($sformatf("%s span", tag), 10'(last_pop - first_pop), 10'(n - 1));
        end else begin
            chk($sformatf("%s stall_accepts", tag), 10'(stall_acc), 10'd2);
            chk($sformatf("%s ready_dropped", tag), {9'b0, ro_low}, 10'd1);
        end
        @(posedge clk); #1;
        chk($sformatf("%s drained", tag), {9'b0, valid_out}, 10'd0);
        in_q.delete();
        exp_q.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst valid_out", {9'b0, valid_out}, 10'd0);
        chk("rst code_out", code_out, 10'h000);
        chk("rst rd_out", {9'b0, rd_out}, 10'd0);
        chk("rst kerr_out", {9'b0, kerr_out}, 10'd0);
        chk("rst ready_out", {9'b0, ready_out}, 10'd1);
        rst = 1'b0;

        add(1'b0, 8'h00, 10'b1001110100, 1'b0, 1'b0);
        run_stream("d0_0", 0);

        add(1'b1, 8'hBC, 10'b0011111010, 1'b1, 1'b0);
        add(1'b1, 8'hBC, 10'b1100000101, 1'b0, 1'b0);
        run_stream("k28_5", 0);

        repeat (4) add(1'b0, 8'hB5, 10'b1010101010, 1'b0, 1'b0);
        run_stream("d21_5", 0);

        add(1'b0, 8'hF1, 10'b1000110111, 1'b1, 1'b0);
        add(1'b1, 8'hBC, 10'b1100000101, 1'b0, 1'b0);
        add(1'b1, 8'hBC, 10'b0011111010, 1'b1, 1'b0);
        add(1'b0, 8'hF1, 10'b1000110001, 1'b0, 1'b0);
        add(1'b1, 8'hBC, 10'b0011111010, 1'b1, 1'b0);
        add(1'b0, 8'hEB, 10'b1101001000, 1'b0, 1'b0);
        add(1'b0, 8'h67, 10'b1110001100, 1'b0, 1'b0);
        add(1'b1, 8'hBC, 10'b0011111010, 1'b1, 1'b0);
        add(1'b0, 8'h67, 10'b0001110011, 1'b1, 1'b0);
        run_stream("alt_a7", 0);

        add(1'b0, 8'h00, 10'b0110001011, 1'b1, 1'b0);
        add(1'b0, 8'hB5, 10'b1010101010, 1'b1, 1'b0);
        add(1'b1, 8'hBC, 10'b1100000101, 1'b0, 1'b0);
        add(1'b0, 8'h23, 10'b1100011001, 1'b0, 1'b0);
        run_stream("stall", 5);

`ifdef ENC8B10B_KERR_EN
        add(1'b1, 8'h00, 10'b0011111010, 1'b1, 1'b1);
        add(1'b0, 8'hB5, 10'b1010101010, 1'b1, 1'b0);
        add(1'b0, 8'h00, 10'b0110001011, 1'b1, 1'b0);
        add(1'b1, 8'hF7, 10'b0001010111, 1'b1, 1'b0);
        add(1'b1, 8'hFC, 10'b1100000111, 1'b1, 1'b0);
`else
        add(1'b1, 8'h00, 10'b1001110100, 1'b0, 1'b0);
        add(1'b0, 8'hB5, 10'b1010101010, 1'b0, 1'b0);
        add(1'b0, 8'h00, 10'b1001110100, 1'b0, 1'b0);
        add(1'b1, 8'hF7, 10'b1110101000, 1'b0, 1'b0);
        add(1'b1, 8'hFC, 10'b0011111000, 1'b0, 1'b0);
`endif
        run_stream("kchk", 0);

        valid_in = 1'b1;
        k_in     = 1'b1;
        data_in  = 8'hBC;
        repeat (3) begin
            @(posedge clk); #1;
        end
        #3 rst = 1'b1;
        #1;
        chk("midrst valid_out", {9'b0, valid_out}, 10'd0);
        chk("midrst rd_out", {9'b0, rd_out}, 10'd0);
        chk("midrst code_out", code_out, 10'h000);
        chk("midrst kerr_out", {9'b0, kerr_out}, 10'd0);
        valid_in = 1'b0;
        k_in     = 1'b0;
        data_in  = '0;
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk($sformatf("post_rst idle%0d", i), {9'b0, valid_out}, 10'd0);
        end

        add(1'b0, 8'h00, 10'b1001110100, 1'b0, 1'b0);
        run_stream("after_rst", 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
